// File: rtl/alu_rr_arbiter_pkg.sv
// Shared ALU control codes, arbiter FSM encodings and the ALU32FF datapath.
// ALU32FF is a pure combinational function of ctl/op1/op2.
package alu_rr_arbiter_pkg;

    localparam int CTLW = 16;
    localparam int XLEN = 32;

    localparam logic [CTLW-1:0] ALU_CTL_ADD  = 16'h0001;
    localparam logic [CTLW-1:0] ALU_CTL_SUB  = 16'h0002;
    localparam logic [CTLW-1:0] ALU_CTL_AND  = 16'h0003;
    localparam logic [CTLW-1:0] ALU_CTL_OR   = 16'h0004;
    localparam logic [CTLW-1:0] ALU_CTL_XOR  = 16'h0005;
    localparam logic [CTLW-1:0] ALU_CTL_SLL  = 16'h0006;
    localparam logic [CTLW-1:0] ALU_CTL_SRL  = 16'h0007;
    localparam logic [CTLW-1:0] ALU_CTL_SRA  = 16'h0008;
    localparam logic [CTLW-1:0] ALU_CTL_SLT  = 16'h0009;
    localparam logic [CTLW-1:0] ALU_CTL_SLTU = 16'h000A;
    localparam logic [CTLW-1:0] ALU_CTL_DIV  = 16'h000B;
    localparam logic [CTLW-1:0] ALU_CTL_DIVU = 16'h000C;
    localparam logic [CTLW-1:0] ALU_CTL_REM  = 16'h000D;
    localparam logic [CTLW-1:0] ALU_CTL_REMU = 16'h000E;

    typedef enum logic {
        ARB_ST_EMPTY = 1'b0,
        ARB_ST_FULL  = 1'b1
    } arb_st_t;

    typedef struct packed {
        logic [CTLW-1:0] ctl;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } alu_req_t;

    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL1    = 32'hFFFF_FFFF;

    // Division follows RISC-V M semantics so no case is undefined:
    // x/0 = all ones, x%0 = x, INT_MIN/-1 = INT_MIN, INT_MIN%-1 = 0.
    function automatic logic [XLEN-1:0] alu32ff(
        input logic [CTLW-1:0] ctl,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        logic ovf;
        r   = '0;
        ovf = (a == INT_MIN) && (b == ALL1);
        case (ctl)
            ALU_CTL_ADD:  r = a + b;
            ALU_CTL_SUB:  r = a - b;
            ALU_CTL_AND:  r = a & b;
            ALU_CTL_OR:   r = a | b;
            ALU_CTL_XOR:  r = a ^ b;
            ALU_CTL_SLL:  r = a << b[4:0];
            ALU_CTL_SRL:  r = a >> b[4:0];
            ALU_CTL_SRA:  r = $signed(a) >>> b[4:0];
            ALU_CTL_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_CTL_SLTU: r = {31'b0, a < b};
            ALU_CTL_DIV: begin
                if (b == '0)   r = ALL1;
                else if (ovf)  r = a;
                else           r = $signed(a) / $signed(b);
            end
            ALU_CTL_DIVU: r = (b == '0) ? ALL1 : a / b;
            ALU_CTL_REM: begin
                if (b == '0)   r = a;
                else if (ovf)  r = '0;
                else           r = $signed(a) % $signed(b);
            end
            ALU_CTL_REMU: r = (b == '0) ? a : a % b;
            default:      r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_grant.sv
// Round-robin grant: first set bit of req at or above ptr, with wrap.
// Ports: req (NREQ), ptr (IDW) in; grant (one-hot/zero), idx (IDW) out.
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    int   c;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin share of one ALU32FF among NREQ requesters, 1-entry rsp buffer.
// Ports: clk, rst_n, req_vld/rdy/ctl/op1/op2 (packed per requester),
// rsp_vld/rdy/id/res/err. Macro ALU_ARB_DIV0_TRAP_EN enables div-by-0 flag.
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_vld,
    output logic [NREQ-1:0]    req_rdy,
    input  logic [NREQ*16-1:0] req_ctl,
    input  logic [NREQ*32-1:0] req_op1,
    input  logic [NREQ*32-1:0] req_op2,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_res,
    output logic               rsp_err
);

    arb_st_t         state;
    arb_st_t         state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            accept;
    logic            xfer;
    alu_req_t        sel;
    logic [31:0]     alu_res;
    logic [31:0]     res_nxt;
    logic [31:0]     res_q;
    logic [IDW-1:0]  id_q;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_grant (
        .req   (req_vld),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // One-hot grant makes an OR-mux sufficient; no grant yields zeros.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.ctl = req_ctl[16*i +: 16];
                sel.op1 = req_op1[32*i +: 32];
                sel.op2 = req_op2[32*i +: 32];
            end
        end
    end

    assign alu_res = alu32ff(sel.ctl, sel.op1, sel.op2);

`ifdef ALU_ARB_DIV0_TRAP_EN
    logic err_nxt;
    logic err_q;
    logic div0;
    logic rem0;

    always_comb begin
        div0    = (sel.ctl == ALU_CTL_DIV) && (sel.op2 == '0);
        rem0    = (sel.ctl == ALU_CTL_REM) && (sel.op2 == '0);
        err_nxt = div0 | rem0;
        res_nxt = alu_res;
        if (div0) res_nxt = 32'hFFFF_FFFF;
        if (rem0) res_nxt = sel.op1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    err_q <= 1'b0;
        else if (xfer) err_q <= err_nxt;
    end

    assign rsp_err = err_q;
`else
    assign res_nxt = alu_res;
    assign rsp_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_ST_EMPTY;
        else        state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_ST_EMPTY: begin
                if (xfer) state_nxt = ARB_ST_FULL;
            end
            ARB_ST_FULL: begin
                if (rsp_rdy && !xfer) state_nxt = ARB_ST_EMPTY;
            end
            default: state_nxt = ARB_ST_EMPTY;
        endcase
    end

    // FSM outputs; rst_n gating keeps req_rdy low while held in reset.
    always_comb begin
        rsp_vld = (state == ARB_ST_FULL);
        accept  = !rsp_vld || rsp_rdy;
        req_rdy = grant & {NREQ{accept & rst_n}};
        xfer    = |req_rdy;
    end

    always_comb begin
        if (gidx == IDW'(NREQ - 1)) ptr_nxt = '0;
        else                        ptr_nxt = gidx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            res_q <= '0;
            id_q  <= '0;
        end else if (xfer) begin
            ptr   <= ptr_nxt;
            res_q <= res_nxt;
            id_q  <= gidx;
        end
    end

    assign rsp_res = res_q;
    assign rsp_id  = id_q;

endmodule
